// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source end of a 4-phase req/ack handshake.
// It captures a word, holds it on o_data_out, raises o_req_out, and then walks the
// req/ack cycle. i_ack_in comes from the destination domain and is resynchronized here.
module cdc_hs_tx #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_req_out,
    input  logic                  i_ack_in,
    output logic                  o_done,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT_ACK_HI,
        ST_WAIT_ACK_LO
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_ack_sync;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_req;
    logic                    r_done;

    logic                    w_ack_sync;
    logic                    w_accept;

    assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];

    // A stale-high ack blocks new words until the destination has released it.
    assign o_tx_ready = (r_state == ST_IDLE) && !w_ack_sync;
    assign w_accept   = i_tx_valid && o_tx_ready;

    assign o_data_out = r_data;
    assign o_req_out  = r_req;
    assign o_done     = r_done;
    assign o_busy     = (r_state != ST_IDLE);

    // Multi-flop synchronizer for the asynchronous acknowledge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_ack_in};
        end
    end

    // Handshake FSM with registered data, request and done outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data  <= i_tx_data;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // Data has been stable for one cycle before the request rises.
                    r_req   <= 1'b1;
                    r_state <= ST_WAIT_ACK_HI;
                end
                ST_WAIT_ACK_HI: begin
                    if (w_ack_sync) begin
                        r_req   <= 1'b0;
                        r_state <= ST_WAIT_ACK_LO;
                    end
                end
                ST_WAIT_ACK_LO: begin
                    // An ack that re-rises here just extends the wait; the request stays low.
                    if (!w_ack_sync) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
